// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: default width, op codes and FSM states.
package alu_seq_pkg;

    localparam int ALU_WIDTH_DEF = 32;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_XOR  = 4'd2,
        OP_ADDS = 4'd3,
        OP_ADDU = 4'd4,
        OP_SUBS = 4'd5,
        OP_SUBU = 4'd6,
        OP_SHRL = 4'd7,
        OP_SHLL = 4'd8,
        OP_SHRA = 4'd9,
        OP_MULU = 4'd10,
        OP_DIVU = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per step.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    output logic             last,
    output logic [WIDTH-1:0] nxt_lo,
    output logic [WIDTH-1:0] nxt_hi
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_tr;

    // hi holds the partial product / remainder, lo the multiplier / quotient.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH + 1){1'b0}});
    assign div_sh  = {hi_q, lo_q[WIDTH-1]};
    assign div_tr  = div_sh - {1'b0, a_q};

    always_comb begin
        nxt_hi = hi_q;
        nxt_lo = lo_q;
        if (is_div) begin
            if (div_tr[WIDTH]) begin
                nxt_hi = div_sh[WIDTH-1:0];
                nxt_lo = {lo_q[WIDTH-2:0], 1'b0};
            end else begin
                nxt_hi = div_tr[WIDTH-1:0];
                nxt_lo = {lo_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // The step in which the counter sits at one produces the final result.
    assign last = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            a_q   <= in_1;
            hi_q  <= '0;
            lo_q  <= in_0;
            cnt_q <= CNT_W'(WIDTH);
        end else if (step) begin
            a_q   <= a_q;
            hi_q  <= nxt_hi;
            lo_q  <= nxt_lo;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus iterative MULU/DIVU.
//   state | meaning
//   IDLE  | waiting for start
//   MUL   | shift-add multiply in progress
//   DIV   | restoring divide in progress
//   DONE  | result registered, valid asserted
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEF,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             of,
    output logic             dz
);

    state_e state_q, state_d;

    logic             md_load;
    logic             md_last;
    logic             cap;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic [WIDTH-1:0] alu_lo, alu_hi;
    logic             alu_of, alu_dz;
    logic [WIDTH-1:0] res_lo, res_hi;
    logic             res_of, res_dz;
    logic [WIDTH-1:0] sum, diff;
    logic [SH_W-1:0]  sh_amt;
    logic             in1_zero;

    assign sum      = in_0 + in_1;
    assign diff     = in_0 - in_1;
    assign sh_amt   = in_1[SH_W-1:0];
    assign in1_zero = (in_1 == '0);

    assign busy  = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign valid = (state_q == ST_DONE);

    always_comb begin
        alu_lo = in_0;
        alu_hi = '0;
        alu_of = 1'b0;
        alu_dz = 1'b0;
        case (op_e'(op))
            OP_AND:  alu_lo = in_0 & in_1;
            OP_OR:   alu_lo = in_0 | in_1;
            OP_XOR:  alu_lo = in_0 ^ in_1;
            OP_ADDS: begin
                alu_lo = sum;
                alu_of = (in_0[WIDTH-1] == in_1[WIDTH-1]) && (sum[WIDTH-1] != in_0[WIDTH-1]);
            end
            OP_ADDU: alu_lo = sum;
            OP_SUBS: begin
                alu_lo = diff;
                alu_of = (in_0[WIDTH-1] != in_1[WIDTH-1]) && (diff[WIDTH-1] != in_0[WIDTH-1]);
            end
            OP_SUBU: alu_lo = diff;
            OP_SHRL: alu_lo = in_0 >> sh_amt;
            OP_SHLL: alu_lo = in_0 << sh_amt;
            OP_SHRA: alu_lo = $signed(in_0) >>> sh_amt;
            // Only the divide-by-zero case of DIVU completes here.
            OP_DIVU: begin
                alu_lo = '1;
                alu_hi = in_0;
                alu_dz = 1'b1;
            end
            default: alu_lo = in_0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        md_load = 1'b0;
        cap     = 1'b0;
        res_lo  = alu_lo;
        res_hi  = alu_hi;
        res_of  = alu_of;
        res_dz  = alu_dz;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    if (op == OP_MULU) begin
                        state_d = ST_MUL;
                        md_load = 1'b1;
                    end else if (op == OP_DIVU && !in1_zero) begin
                        state_d = ST_DIV;
                        md_load = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        cap     = 1'b1;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                res_lo = md_lo;
                res_hi = md_hi;
                res_of = 1'b0;
                res_dz = 1'b0;
                if (md_last) begin
                    state_d = ST_DONE;
                    cap     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out    <= '0;
            out_hi <= '0;
            of     <= 1'b0;
            dz     <= 1'b0;
        end else if (cap) begin
            out    <= res_lo;
            out_hi <= res_hi;
            of     <= res_of;
            dz     <= res_dz;
        end
    end

    muldiv_seq #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .load   (md_load),
        .step   (busy),
        .is_div (state_q == ST_DIV),
        .in_0   (in_0),
        .in_1   (in_1),
        .last   (md_last),
        .nxt_lo (md_lo),
        .nxt_hi (md_hi)
    );

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed corner cases plus random ops vs. an arithmetic model.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] in_0, in_1;
    logic         busy, valid, of, dz;
    logic [W-1:0] out, out_hi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .in_0   (in_0),
        .in_1   (in_1),
        .busy   (busy),
        .valid  (valid),
        .out    (out),
        .out_hi (out_hi),
        .of     (of),
        .dz     (dz)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi,
                                  output logic eof, output logic edz, output int lat);
        longint sa, sb, s;
        logic [63:0] p;
        int sh;
        sa  = $signed(a);
        sb  = $signed(b);
        sh  = int'(b % 32);
        lo  = a;
        hi  = '0;
        eof = 1'b0;
        edz = 1'b0;
        lat = 1;
        case (o)
            4'd0:  lo = a & b;
            4'd1:  lo = a | b;
            4'd2:  lo = a ^ b;
            4'd3:  begin
                s   = sa + sb;
                lo  = s[31:0];
                eof = (s > SMAX) || (s < SMIN);
            end
            4'd4:  lo = a + b;
            4'd5:  begin
                s   = sa - sb;
                lo  = s[31:0];
                eof = (s > SMAX) || (s < SMIN);
            end
            4'd6:  lo = a - b;
            4'd7:  lo = a >> sh;
            4'd8:  lo = a << sh;
            4'd9:  lo = $signed(a) >>> sh;
            4'd10: begin
                p   = {32'd0, a} * {32'd0, b};
                lo  = p[31:0];
                hi  = p[63:32];
                lat = W + 1;
            end
            4'd11: begin
                if (b == 0) begin
                    lo  = '1;
                    hi  = a;
                    edz = 1'b1;
                end else begin
                    lo  = a / b;
                    hi  = a % b;
                    lat = W + 1;
                end
            end
            default: lo = a;
        endcase
    endfunction

    // Issues one op, optionally pokes start(ADDU) at cycle inj while busy, and checks the result.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int inj, input bit hold);
        logic [W-1:0] elo, ehi;
        logic eof, edz;
        int elat, cyc, bcyc;
        model(o, a, b, elo, ehi, eof, edz, elat);
        @(negedge clk);
        start = 1'b1; op = o; in_0 = a; in_1 = b;
        @(negedge clk);
        start = 1'b0; op = 4'($urandom); in_0 = $urandom; in_1 = $urandom;
        cyc  = 1;
        bcyc = 0;
        while (!valid && cyc <= W + 5) begin
            if (busy) bcyc++;
            if (cyc == inj) begin
                start = 1'b1;
                op    = OP_ADDU;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk({tag, ".valid"},   64'(valid), 64'd1);
        chk({tag, ".latency"}, 64'(cyc), 64'(elat));
        chk({tag, ".busycyc"}, 64'(bcyc), 64'(elat - 1));
        chk({tag, ".out"},     64'(out), 64'(elo));
        chk({tag, ".out_hi"},  64'(out_hi), 64'(ehi));
        chk({tag, ".of"},      64'(of), 64'(eof));
        chk({tag, ".dz"},      64'(dz), 64'(edz));
        if (hold) begin
            @(negedge clk);
            chk({tag, ".pulse"}, 64'(valid), 64'd0);
            chk({tag, ".hold"},  64'(out), 64'(elo));
        end
    endtask

    initial begin
        int nval;
        logic [3:0] ro;
        logic [W-1:0] ra, rb;

        reset = 1'b1; start = 1'b0; op = '0; in_0 = '0; in_1 = '0;
        #1;
        chk("rst.busy",   64'(busy), 64'd0);
        chk("rst.valid",  64'(valid), 64'd0);
        chk("rst.out",    64'(out), 64'd0);
        chk("rst.out_hi", 64'(out_hi), 64'd0);
        chk("rst.of",     64'(of), 64'd0);
        chk("rst.dz",     64'(dz), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        run_op("adds_ovf", OP_ADDS, 32'h7FFF_FFFF, 32'h0000_0001, 0, 1);
        run_op("addu",     OP_ADDU, 32'h7FFF_FFFF, 32'h0000_0001, 0, 1);
        run_op("subs_ovf", OP_SUBS, 32'h8000_0000, 32'h0000_0001, 0, 1);
        run_op("mulu",     OP_MULU, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1);
        run_op("divu",     OP_DIVU, 32'd100, 32'd7, 0, 1);
        run_op("divu_z",   OP_DIVU, 32'd5, 32'd0, 0, 1);
        run_op("after_dz", OP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 0, 1);
        run_op("shra",     OP_SHRA, 32'h8000_0000, 32'd4, 0, 1);
        run_op("shll33",   OP_SHLL, 32'h0000_0001, 32'd33, 0, 1);
        run_op("mulu_inj", OP_MULU, 32'h1234_5678, 32'h9ABC_DEF0, 10, 1);

        // New start in the DONE cycle is accepted and completes one cycle later.
        run_op("mul_b2b", OP_MULU, 32'h0000_0003, 32'h0000_0005, 0, 0);
        start = 1'b1; op = OP_XOR; in_0 = 32'hA5A5_0F0F; in_1 = 32'h0F0F_FFFF;
        @(negedge clk);
        start = 1'b0;
        chk("b2b.valid",  64'(valid), 64'd1);
        chk("b2b.out",    64'(out), 64'hAA_AAF0F0);
        chk("b2b.out_hi", 64'(out_hi), 64'd0);
        @(negedge clk);
        chk("b2b.pulse",  64'(valid), 64'd0);

        // Reset in the middle of a multiply aborts it.
        @(negedge clk);
        start = 1'b1; op = OP_MULU; in_0 = 32'h0000_FFFF; in_1 = 32'h0001_0001;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort.busy_pre", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("abort.busy",  64'(busy), 64'd0);
        chk("abort.out",   64'(out), 64'd0);
        chk("abort.valid", 64'(valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        nval = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) nval++;
        end
        chk("abort.novalid", 64'(nval), 64'd0);
        run_op("post_rst", OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 0, 1);

        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 3));
            run_op($sformatf("rand%0d", i), ro, ra, rb, 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
